eth_phy_mgr: RTL and testbench
==============================

# eth_phy_mgr

Autonomous PHY management sequencer that sits directly upstream of eth_mdio and drives its request interface. After enable it soft-resets the PHY, reads PHY ID1, enables and restarts auto-negotiation, then periodically polls the Basic Mode Status Register (BMSR) to publish link and auto-negotiation status. It runs on the same Clk as eth_mdio and replaces software-driven MDIO accesses for bring-up.

## Interface
- PHY_ADDR, 5'h01, MDIO PHY address used for every transaction
- RST_WAIT, 16'd1000, Clk cycles to wait after the BMCR soft-reset write
- POLL_PERIOD, 24'd1_000_000, Clk cycles between BMSR reads
- TIMEOUT, 16'd256, maximum Clk cycles for one MDIO transaction, measured from En assertion
- Clk  in  1  clock, shared with eth_mdio
- Rst  in  1  reset, synchronous, active-high
- Mgr_En  in  1  level; high runs the sequencer
- MDIO_Phy_Addr_Recv  out  5  PHY address to eth_mdio
- MDIO_Reg_Addr_Recv  out  5  register address to eth_mdio
- MDIO_Transc_Type_Recv  out  1  0 = read, 1 = write
- MDIO_En_Recv  out  1  transaction request level
- MDIO_Wr_Dat_Recv  out  16  write data
- MDIO_Busy  in  1  eth_mdio busy
- MDIO_Data_Valid  in  1  one-cycle read-data strobe
- MDIO_Data  in  32  read data; only bits [15:0] are used
- Link_Up  out  1  BMSR[2] from the last successful poll
- An_Done  out  1  BMSR[5] from the last successful poll
- Phy_Id1  out  16  PHY ID register 2 contents
- Init_Done  out  1  high once the init sequence has completed
- Mgr_Err  out  1  sticky transaction-timeout or missing-data flag

## Operation
- Main FSM states: IDLE, WR_RST, RST_WAIT, RD_ID, WR_AN, POLL_WAIT, RD_BMSR, HALT.
- IDLE -> WR_RST when Mgr_En=1 and Mgr_Err=0.
- WR_RST: write reg 0 = 16'h8000 -> RST_WAIT.
- RST_WAIT: count RST_WAIT cycles -> RD_ID.
- RD_ID: read reg 2, latch Phy_Id1 -> WR_AN.
- WR_AN: write reg 0 = 16'h1200 (AN enable + restart). Set Init_Done -> POLL_WAIT.
- POLL_WAIT: count POLL_PERIOD cycles -> RD_BMSR.
- RD_BMSR: read reg 1, update Link_Up and An_Done -> POLL_WAIT.
- Transaction sub-FSM states: T_IDLE, T_REQ, T_ACT, T_GAP.
  - T_REQ: drive address, type and data; assert MDIO_En_Recv; hold it until MDIO_Busy=1 is seen, then deassert -> T_ACT.
  - T_ACT: on MDIO_Data_Valid, capture MDIO_Data[15:0]. When MDIO_Busy falls -> T_GAP.
  - T_GAP: hold MDIO_En_Recv low for 4 cycles, so eth_mdio's synchronizer plus edge detector sees the next rising edge -> T_IDLE and signal done to the main FSM.
- Request outputs hold stable from T_REQ entry to T_GAP exit.
- Timeout: a counter starts at En assertion and clears at done. Reaching TIMEOUT, or a read whose Busy falls with no Data_Valid seen, sets Mgr_Err, drops En and moves to HALT.
- HALT: leaves only via Rst. Status outputs keep their last values.
- Mgr_En falling mid-transaction: the in-flight transaction completes, then -> IDLE and Init_Done clears. Link_Up, An_Done and Phy_Id1 hold. Re-enabling restarts from WR_RST.
- Mgr_En falling during RST_WAIT or POLL_WAIT: -> IDLE next cycle.
- Counters are saturating-free. Each counter is compared with == (parameter − 1) and cleared on state entry.

## Timing
- Reset values: every output is 0. MDIO_Phy_Addr_Recv = PHY_ADDR constant is permitted.
- Enable to first request: MDIO_En_Recv rises 2 cycles after Mgr_En is sampled high (IDLE -> WR_RST -> T_REQ).
- MDIO_Busy rises 3 cycles after MDIO_En_Recv. MDIO_En_Recv falls on the cycle after Busy=1 is sampled.
- Status update: Link_Up, An_Done and Phy_Id1 update on the cycle after MDIO_Data_Valid=1.
- Init_Done rises on the cycle the WR_AN transaction's T_GAP completes.
- Simultaneous events: Mgr_En=0 in the same cycle as a timeout gives Mgr_Err=1 and HALT (error wins).
- Rst overrides everything at any point, including mid-frame. eth_mdio must be reset together with this block.

## Test plan
- Init sequence (RST_WAIT=10, POLL_PERIOD=200, eth_mdio in SIM_MODE) -> writes observed in order: reg 0 = 0x8000, then read reg 2, then reg 0 = 0x1200. Init_Done=1 after the last write.
- PHY model returns ID 0x0022 for reg 2 -> Phy_Id1 = 16'h0022.
- BMSR model returns 0x7809, then 0x782D on the next poll -> Link_Up 0->1 and An_Done 0->1 on the second poll. The gap between BMSR reads is ≥ 200 cycles.
- Busy model that never asserts Busy -> Mgr_En... specifically, Mgr_Err=1 exactly TIMEOUT cycles after En rises, En=0, no further requests, until Rst.
- Mgr_En dropped mid RD_BMSR frame -> the frame completes, Link_Up reflects that read, Init_Done=0. Re-enable -> a new write of 0x8000 is issued.
- Back-to-back transactions -> MDIO_En_Recv is low for ≥ 4 cycles between requests and eth_mdio starts every frame (no lost rising edge).

Source files
------------

// File: rtl/eth_phy_mgr.sv
// PHY bring-up sequencer for eth_mdio: soft reset, ID1 read, AN restart, then periodic BMSR polling.
// First request 2 cycles after enable; each request is held until eth_mdio shows Busy, and a stuck or dataless frame latches Mgr_Err.
module eth_phy_mgr #(
    parameter logic [4:0]  PHY_ADDR    = 5'h01,
    parameter logic [15:0] RST_WAIT    = 16'd1000,
    parameter logic [23:0] POLL_PERIOD = 24'd1_000_000,
    parameter logic [15:0] TIMEOUT     = 16'd256
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Mgr_En,
    output logic [4:0]  MDIO_Phy_Addr_Recv,
    output logic [4:0]  MDIO_Reg_Addr_Recv,
    output logic        MDIO_Transc_Type_Recv,
    output logic        MDIO_En_Recv,
    output logic [15:0] MDIO_Wr_Dat_Recv,
    input  logic        MDIO_Busy,
    input  logic        MDIO_Data_Valid,
    input  logic [31:0] MDIO_Data,
    output logic        Link_Up,
    output logic        An_Done,
    output logic [15:0] Phy_Id1,
    output logic        Init_Done,
    output logic        Mgr_Err
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_RST, S_RST_WAIT, S_RD_ID, S_WR_AN, S_POLL_WAIT, S_RD_BMSR, S_HALT
    } mainState_t;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_ACT, T_GAP} xactState_t;

    localparam logic [23:0] RST_LAST  = {8'd0, RST_WAIT} - 24'd1;
    localparam logic [23:0] POLL_LAST = POLL_PERIOD - 24'd1;
    localparam logic [15:0] TMO_LAST  = TIMEOUT - 16'd1;

    mainState_t  mState;
    xactState_t  tState;
    logic [23:0] waitCnt;
    logic [15:0] tmoCnt;
    logic [1:0]  gapCnt;
    logic        seenValid;
    logic        reqWr;
    logic [4:0]  reqReg;
    logic [15:0] reqDat;
    logic        inXact;
    logic        tDone;
    logic        tmoHit;
    logic        noData;
    logic        unusedDataHi;

    assign unusedDataHi       = ^MDIO_Data[31:16];
    assign MDIO_Phy_Addr_Recv = PHY_ADDR;

    assign inXact = (mState == S_WR_RST) || (mState == S_RD_ID) ||
                    (mState == S_WR_AN)  || (mState == S_RD_BMSR);
    assign tDone  = (tState == T_GAP) && (gapCnt == 2'd3);
    assign tmoHit = (tState != T_IDLE) && (tmoCnt == TMO_LAST);
    // A read whose frame ends without a data strobe is as fatal as a hung frame.
    assign noData = (tState == T_ACT) && !MDIO_Busy && !MDIO_Transc_Type_Recv &&
                    !seenValid && !MDIO_Data_Valid;

    always_comb begin
        reqWr  = 1'b0;
        reqReg = 5'd0;
        reqDat = 16'h0000;
        case (mState)
            S_WR_RST:  begin reqWr = 1'b1; reqDat = 16'h8000; end
            S_RD_ID:   reqReg = 5'd2;
            S_WR_AN:   begin reqWr = 1'b1; reqDat = 16'h1200; end
            S_RD_BMSR: reqReg = 5'd1;
            default:   ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mState                <= S_IDLE;
            tState                <= T_IDLE;
            waitCnt               <= '0;
            tmoCnt                <= '0;
            gapCnt                <= '0;
            seenValid             <= 1'b0;
            MDIO_Reg_Addr_Recv    <= '0;
            MDIO_Transc_Type_Recv <= 1'b0;
            MDIO_En_Recv          <= 1'b0;
            MDIO_Wr_Dat_Recv      <= '0;
            Link_Up               <= 1'b0;
            An_Done               <= 1'b0;
            Phy_Id1               <= '0;
            Init_Done             <= 1'b0;
            Mgr_Err               <= 1'b0;
        end else begin
            case (tState)
                T_IDLE: if (inXact) begin
                    tState                <= T_REQ;
                    MDIO_En_Recv          <= 1'b1;
                    MDIO_Reg_Addr_Recv    <= reqReg;
                    MDIO_Transc_Type_Recv <= reqWr;
                    MDIO_Wr_Dat_Recv      <= reqDat;
                    tmoCnt                <= '0;
                    seenValid             <= 1'b0;
                end
                T_REQ: begin
                    tmoCnt <= tmoCnt + 16'd1;
                    if (MDIO_Busy) begin
                        MDIO_En_Recv <= 1'b0;
                        tState       <= T_ACT;
                    end
                end
                T_ACT: begin
                    tmoCnt <= tmoCnt + 16'd1;
                    if (MDIO_Data_Valid) begin
                        seenValid <= 1'b1;
                        if (mState == S_RD_ID)
                            Phy_Id1 <= MDIO_Data[15:0];
                        if (mState == S_RD_BMSR) begin
                            Link_Up <= MDIO_Data[2];
                            An_Done <= MDIO_Data[5];
                        end
                    end
                    if (!MDIO_Busy) begin
                        tState <= T_GAP;
                        gapCnt <= '0;
                    end
                end
                T_GAP: begin
                    tmoCnt <= tmoCnt + 16'd1;
                    gapCnt <= gapCnt + 2'd1;
                    if (gapCnt == 2'd3)
                        tState <= T_IDLE;
                end
                default: tState <= T_IDLE;
            endcase

            case (mState)
                S_IDLE: begin
                    Init_Done <= 1'b0;
                    if (Mgr_En && !Mgr_Err)
                        mState <= S_WR_RST;
                end
                S_WR_RST: if (tDone) begin
                    mState    <= Mgr_En ? S_RST_WAIT : S_IDLE;
                    waitCnt   <= '0;
                    Init_Done <= 1'b0;
                end
                S_RST_WAIT: begin
                    if (!Mgr_En)
                        mState <= S_IDLE;
                    else if (waitCnt == RST_LAST)
                        mState <= S_RD_ID;
                    else
                        waitCnt <= waitCnt + 24'd1;
                end
                S_RD_ID: if (tDone)
                    mState <= Mgr_En ? S_WR_AN : S_IDLE;
                S_WR_AN: if (tDone) begin
                    mState    <= Mgr_En ? S_POLL_WAIT : S_IDLE;
                    Init_Done <= Mgr_En;
                    waitCnt   <= '0;
                end
                S_POLL_WAIT: begin
                    if (!Mgr_En) begin
                        mState    <= S_IDLE;
                        Init_Done <= 1'b0;
                    end else if (waitCnt == POLL_LAST)
                        mState <= S_RD_BMSR;
                    else
                        waitCnt <= waitCnt + 24'd1;
                end
                S_RD_BMSR: if (tDone) begin
                    mState    <= Mgr_En ? S_POLL_WAIT : S_IDLE;
                    Init_Done <= Mgr_En;
                    waitCnt   <= '0;
                end
                default: ;
            endcase

            // Error wins over every other transition, including a concurrent disable.
            if (tmoHit || noData) begin
                Mgr_Err      <= 1'b1;
                MDIO_En_Recv <= 1'b0;
                tState       <= T_IDLE;
                mState       <= S_HALT;
            end
        end
    end
endmodule

// File: tb/tb_eth_phy_mgr.sv
// Bench for eth_phy_mgr with a behavioural eth_mdio/PHY model driven on the falling clock edge.
module tb_eth_phy_mgr;
    localparam logic [4:0]  PHY_ADDR    = 5'h01;
    localparam logic [15:0] RST_WAIT    = 16'd10;
    localparam logic [23:0] POLL_PERIOD = 24'd200;
    localparam logic [15:0] TIMEOUT     = 16'd64;
    localparam int          BUSY_LEN    = 8;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Mgr_En;
    logic [4:0]  MDIO_Phy_Addr_Recv;
    logic [4:0]  MDIO_Reg_Addr_Recv;
    logic        MDIO_Transc_Type_Recv;
    logic        MDIO_En_Recv;
    logic [15:0] MDIO_Wr_Dat_Recv;
    logic        MDIO_Busy;
    logic        MDIO_Data_Valid;
    logic [31:0] MDIO_Data;
    logic        Link_Up;
    logic        An_Done;
    logic [15:0] Phy_Id1;
    logic        Init_Done;
    logic        Mgr_Err;

    eth_phy_mgr #(
        .PHY_ADDR(PHY_ADDR), .RST_WAIT(RST_WAIT), .POLL_PERIOD(POLL_PERIOD), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Mgr_En(Mgr_En),
        .MDIO_Phy_Addr_Recv(MDIO_Phy_Addr_Recv), .MDIO_Reg_Addr_Recv(MDIO_Reg_Addr_Recv),
        .MDIO_Transc_Type_Recv(MDIO_Transc_Type_Recv), .MDIO_En_Recv(MDIO_En_Recv),
        .MDIO_Wr_Dat_Recv(MDIO_Wr_Dat_Recv), .MDIO_Busy(MDIO_Busy),
        .MDIO_Data_Valid(MDIO_Data_Valid), .MDIO_Data(MDIO_Data),
        .Link_Up(Link_Up), .An_Done(An_Done), .Phy_Id1(Phy_Id1),
        .Init_Done(Init_Done), .Mgr_Err(Mgr_Err)
    );

    always #5 Clk = ~Clk;

    typedef struct { bit wr; logic [4:0] phy; logic [4:0] regA; logic [15:0] dat; int rise; } req_t;
    typedef struct { logic [15:0] bmsr; bit expLink; bit expAn; } vec_t;

    int checks = 0, errors = 0, cyc = 0;
    req_t reqLog[$];
    int mdioMode = 0;          // 0 normal, 1 never busy, 2 reads end without data strobe
    logic [15:0] idVal = 16'h0022, bmsrVal = 16'h7809;
    int busyFallCyc = -1, minGap = 1000, busyStarts = 0, totalReqs = 0, lostEdges = 0, badPhy = 0;
    int prevBmsrRise = -1;

    always @(posedge Clk) cyc <= cyc + 1;

    // eth_mdio + PHY behaviour: Busy 3 cycles after the En rising edge, data strobe on the last busy cycle.
    initial begin
        bit prevEn;
        int dly, busyLeft;
        bit curWr;
        logic [4:0] curReg;
        logic [15:0] rd;
        req_t r;
        prevEn = 0; dly = 0; busyLeft = 0; curWr = 0; curReg = '0;
        MDIO_Busy = 0; MDIO_Data_Valid = 0; MDIO_Data = '0;
        forever begin
            @(negedge Clk);
            MDIO_Data_Valid = 1'b0;
            if (Rst) begin
                prevEn = 0; dly = 0; busyLeft = 0; MDIO_Busy = 0;
            end else begin
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin MDIO_Busy = 1'b1; busyLeft = BUSY_LEN; busyStarts++; end
                end else if (busyLeft > 0) begin
                    busyLeft--;
                    if (busyLeft == 1 && !curWr && mdioMode != 2) begin
                        rd = (curReg == 5'd2) ? idVal : (curReg == 5'd1) ? bmsrVal : 16'hFFFF;
                        MDIO_Data_Valid = 1'b1;
                        MDIO_Data = {16'($urandom), rd};
                    end
                    if (busyLeft == 0) begin MDIO_Busy = 1'b0; busyFallCyc = cyc; end
                end
                if (MDIO_En_Recv && !prevEn) begin
                    r.wr = MDIO_Transc_Type_Recv; r.phy = MDIO_Phy_Addr_Recv;
                    r.regA = MDIO_Reg_Addr_Recv; r.dat = MDIO_Wr_Dat_Recv; r.rise = cyc;
                    reqLog.push_back(r);
                    totalReqs++;
                    if (r.phy != 5'h01) badPhy++;
                    if (busyFallCyc >= 0 && cyc - busyFallCyc < minGap) minGap = cyc - busyFallCyc;
                    if (dly > 0 || busyLeft > 0) lostEdges++;
                    else if (mdioMode != 1) dly = 2;
                    curWr = r.wr; curReg = r.regA;
                end
                prevEn = MDIO_En_Recv;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(negedge Clk); #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkGe(input string name, input int act, input int lim);
        checks++;
        if (act < lim) begin
            errors++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, lim);
        end
    endtask

    function automatic bit condMet(input int what);
        case (what)
            0: return MDIO_En_Recv;
            1: return Init_Done;
            2: return MDIO_Data_Valid;
            3: return MDIO_Busy;
            4: return Mgr_Err;
            default: return !MDIO_Busy;
        endcase
    endfunction

    task automatic waitUntil(input string name, input int what, input int budget);
        int n = 0;
        while (!condMet(what) && n < budget) begin tick(); n++; end
        if (!condMet(what)) begin
            checks++; errors++;
            $display("FAIL %s: condition not reached within %0d cycles", name, budget);
        end
    endtask

    function automatic logic [21:0] reqKey(input req_t r);
        return {r.wr, r.regA, r.wr ? r.dat : 16'h0000};
    endfunction

    // Reference: BMSR bit 2 is link status, bit 5 is auto-negotiation complete.
    function automatic bit refLink(input logic [15:0] v); return ((int'(v) >> 2) & 1) == 1; endfunction
    function automatic bit refAn(input logic [15:0] v);   return ((int'(v) >> 5) & 1) == 1; endfunction

    task automatic checkInit(input int s, input string name);
        if (reqLog.size() < s + 3) begin
            checks++; errors++;
            $display("FAIL %s: only %0d requests logged, expected %0d", name, reqLog.size(), s + 3);
        end else begin
            check({name, " wr reset"}, 32'(reqKey(reqLog[s])),     32'({1'b1, 5'd0, 16'h8000}));
            check({name, " rd id"},    32'(reqKey(reqLog[s + 1])), 32'({1'b0, 5'd2, 16'h0000}));
            check({name, " wr an"},    32'(reqKey(reqLog[s + 2])), 32'({1'b1, 5'd0, 16'h1200}));
        end
    endtask

    task automatic doPoll(input logic [15:0] v, input bit expLink, input bit expAn);
        req_t r;
        bmsrVal = v;
        waitUntil("bmsr data strobe", 2, 800);
        tick();
        check("link_up after poll", 32'(Link_Up), 32'(expLink));
        check("an_done after poll", 32'(An_Done), 32'(expAn));
        if (reqLog.size() > 0) begin
            r = reqLog[reqLog.size() - 1];
            check("bmsr request", 32'(reqKey(r)), 32'({1'b0, 5'd1, 16'h0000}));
            if (prevBmsrRise >= 0) checkGe("bmsr poll spacing", r.rise - prevBmsrRise, 200);
            prevBmsrRise = r.rise;
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [15:0] v;
        bit lastLink;
        int n, cnt, s;

        vecs[0] = '{16'h7809, 1'b0, 1'b0};
        vecs[1] = '{16'h782D, 1'b1, 1'b1};
        vecs[2] = '{16'h0004, 1'b1, 1'b0};
        vecs[3] = '{16'h0020, 1'b0, 1'b1};
        vecs[4] = '{16'hFFDB, 1'b0, 1'b0};
        vecs[5] = '{16'h0024, 1'b1, 1'b1};

        Rst = 1'b1; Mgr_En = 1'b0;
        repeat (3) tick();
        check("rst en",        32'(MDIO_En_Recv), 0);
        check("rst reg addr",  32'(MDIO_Reg_Addr_Recv), 0);
        check("rst type",      32'(MDIO_Transc_Type_Recv), 0);
        check("rst wr data",   32'(MDIO_Wr_Dat_Recv), 0);
        check("rst link_up",   32'(Link_Up), 0);
        check("rst an_done",   32'(An_Done), 0);
        check("rst phy_id1",   32'(Phy_Id1), 0);
        check("rst init_done", 32'(Init_Done), 0);
        check("rst mgr_err",   32'(Mgr_Err), 0);
        Rst = 1'b0;
        repeat (3) tick();
        check("idle en stays low", 32'(MDIO_En_Recv), 0);

        // Enable to first request latency
        Mgr_En = 1'b1;
        n = 0;
        do begin @(posedge Clk); #1; n++; end while (!MDIO_En_Recv && n < 10);
        check("enable to request cycles", n, 2);

        waitUntil("init done", 1, 600);
        checkInit(0, "init");
        check("phy id1", 32'(Phy_Id1), 32'h0022);
        check("link before first poll", 32'(Link_Up), 0);

        for (int i = 0; i < 6; i++) doPoll(vecs[i].bmsr, vecs[i].expLink, vecs[i].expAn);
        for (int i = 0; i < 5; i++) begin
            v = 16'($urandom);
            doPoll(v, refLink(v), refAn(v));
            lastLink = refLink(v);
        end

        // Disable in the middle of a BMSR frame: the frame finishes and its status lands.
        v = 16'($urandom);
        v[2] = ~lastLink;
        bmsrVal = v;
        waitUntil("bmsr busy", 3, 800);
        Mgr_En = 1'b0;
        waitUntil("bmsr frame end", 5, 50);
        repeat (8) tick();
        check("link after disabled frame", 32'(Link_Up), 32'(refLink(v)));
        check("an after disabled frame",   32'(An_Done), 32'(refAn(v)));
        check("init_done after disable",   32'(Init_Done), 0);
        n = reqLog.size();
        repeat (300) tick();
        check("no requests while disabled", reqLog.size(), n);

        idVal = 16'($urandom);
        s = reqLog.size();
        Mgr_En = 1'b1;
        waitUntil("init done after re-enable", 1, 600);
        checkInit(s, "reinit");
        check("phy id1 after re-enable", 32'(Phy_Id1), 32'(idVal));
        v = 16'($urandom);
        doPoll(v, refLink(v), refAn(v));

        checkGe("en low after busy falls", minGap, 5);
        check("lost request edges", lostEdges, 0);
        check("every request started a frame", busyStarts, totalReqs);
        check("phy address errors", badPhy, 0);

        // Reset mid-operation, then a PHY that never goes busy.
        Mgr_En = 1'b0; Rst = 1'b1;
        repeat (3) tick();
        mdioMode = 1; Rst = 1'b0;
        reqLog.delete();
        tick();
        check("rst mid-run link_up", 32'(Link_Up), 0);
        check("rst mid-run phy_id1", 32'(Phy_Id1), 0);
        Mgr_En = 1'b1;
        waitUntil("timeout request", 0, 10);
        cnt = 0;
        while (!Mgr_Err && cnt < 200) begin
            tick(); cnt++;
            if (cnt == 40) Mgr_En = 1'b0;
        end
        check("timeout cycles from en rise", cnt, 32'(TIMEOUT));
        check("en dropped on timeout", 32'(MDIO_En_Recv), 0);
        Mgr_En = 1'b1;
        repeat (300) tick();
        check("halt issues no requests", reqLog.size(), 1);
        check("mgr_err sticky", 32'(Mgr_Err), 1);
        check("init_done in halt", 32'(Init_Done), 0);

        // Read frame that ends without a data strobe
        Mgr_En = 1'b0; Rst = 1'b1;
        repeat (3) tick();
        check("rst clears mgr_err", 32'(Mgr_Err), 0);
        mdioMode = 2; Rst = 1'b0;
        reqLog.delete();
        Mgr_En = 1'b1;
        waitUntil("missing data error", 4, 600);
        repeat (20) tick();
        check("missing data request count", reqLog.size(), 2);
        check("phy id1 untouched", 32'(Phy_Id1), 0);
        check("en low after missing data", 32'(MDIO_En_Recv), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
